// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte-lane writes, 1- or 2-cycle read latency,
// selectable read-during-write policy and an optional post-reset clear pass.
module ram_dp_be #(
  parameter int AWIDTH     = 8,
  parameter int DWIDTH     = 16,
  parameter int BWIDTH     = 8,
  parameter int READ_LAT   = 1,
  parameter int RDW_MODE   = 0,
  parameter int CLEAR_INIT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_rd,
  input  logic [AWIDTH-1:0]          i_raddr,
  input  logic                       i_wr,
  input  logic [AWIDTH-1:0]          i_waddr,
  input  logic [DWIDTH-1:0]          i_wdata,
  input  logic [DWIDTH/BWIDTH-1:0]   i_wbe,
  output logic [DWIDTH-1:0]          o_rdata,
  output logic                       o_rvalid,
  output logic                       o_busy
);

  localparam int NB    = DWIDTH / BWIDTH;
  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_ADDR = {AWIDTH{1'b1}};
  localparam logic [AWIDTH-1:0] ADDR_ONE  = AWIDTH'(1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_lat
    $error("ram_dp_be: READ_LAT must be 1 or 2");
  end
  if ((BWIDTH <= 0) || ((DWIDTH % BWIDTH) != 0)) begin : g_bad_width
    $error("ram_dp_be: DWIDTH must be an integer multiple of BWIDTH");
  end

  state_t              state_r;
  state_t              state_s;
  logic [AWIDTH-1:0]   cnt_r;
  logic [AWIDTH-1:0]   cnt_s;
  logic [DWIDTH-1:0]   mem_r [DEPTH];
  logic                rd_fire_s;
  logic                wr_fire_s;
  logic [DWIDTH-1:0]   rd_old_s;
  logic [DWIDTH-1:0]   rd_word_s;

  // Replace the lanes of old_word selected by be with the matching lanes of new_word.
  function automatic logic [DWIDTH-1:0] merge_lanes(
    input logic [DWIDTH-1:0] old_word,
    input logic [DWIDTH-1:0] new_word,
    input logic [NB-1:0]     be
  );
    logic [DWIDTH-1:0] res;
    res = old_word;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) begin
        res[k*BWIDTH +: BWIDTH] = new_word[k*BWIDTH +: BWIDTH];
      end else begin
        res[k*BWIDTH +: BWIDTH] = old_word[k*BWIDTH +: BWIDTH];
      end
    end
    return res;
  endfunction

  assign o_busy    = (state_r == ST_CLEAR);
  assign rd_fire_s = (state_r == ST_READY) && i_rd;
  assign wr_fire_s = (state_r == ST_READY) && i_wr;

  // Clear sequencer next state: walk every address once, then stay ready.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == LAST_ADDR) begin
          state_s = ST_READY;
        end else begin
          cnt_s = cnt_r + ADDR_ONE;
        end
      end
      ST_READY: begin
        state_s = ST_READY;
      end
      default: begin
        state_s = ST_READY;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= (CLEAR_INIT != 0) ? ST_CLEAR : ST_READY;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Array write port: clear pass owns it while busy, byte-lane writes afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_r == ST_CLEAR) begin
        mem_r[cnt_r] <= '0;
      end else if (i_wr) begin
        for (int k = 0; k < NB; k++) begin
          if (i_wbe[k]) begin
            mem_r[i_waddr][k*BWIDTH +: BWIDTH] <= i_wdata[k*BWIDTH +: BWIDTH];
          end
        end
      end
    end
  end

  // Read word selection, including same-address forwarding of the merged word.
  always_comb begin
    rd_old_s = mem_r[i_raddr];
    if ((RDW_MODE != 0) && wr_fire_s && (i_waddr == i_raddr)) begin
      rd_word_s = merge_lanes(rd_old_s, i_wdata, i_wbe);
    end else begin
      rd_word_s = rd_old_s;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DWIDTH-1:0] pipe_data_r;
    logic              pipe_valid_r;

    // Capture stage plus output stage; data is frozen at the request edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_data_r  <= '1;
        pipe_valid_r <= 1'b0;
        o_rdata      <= '1;
        o_rvalid     <= 1'b0;
      end else begin
        pipe_valid_r <= rd_fire_s;
        if (rd_fire_s) begin
          pipe_data_r <= rd_word_s;
        end
        o_rvalid <= pipe_valid_r;
        if (pipe_valid_r) begin
          o_rdata <= pipe_data_r;
        end
      end
    end
  end else begin : g_lat1
    // Single output stage; o_rdata holds when no read completes.
    always_ff @(posedge clk) begin
      if (rst) begin
        o_rdata  <= '1;
        o_rvalid <= 1'b0;
      end else begin
        o_rvalid <= rd_fire_s;
        if (rd_fire_s) begin
          o_rdata <= rd_word_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: directed scenarios plus random traffic, all checked
// against a word-array reference model with a read-result delay queue.
module tb_ram_dp_be;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int BW    = 8;
  localparam int NB    = DW / BW;
  localparam int LAT   = 2;
  localparam int RDW   = 1;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_rd;
  logic [AW-1:0] i_raddr;
  logic          i_wr;
  logic [AW-1:0] i_waddr;
  logic [DW-1:0] i_wdata;
  logic [NB-1:0] i_wbe;
  logic [DW-1:0] o_rdata;
  logic          o_rvalid;
  logic          o_busy;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  int            busy_left = 0;
  logic [DW-1:0] exp_rdata = '1;
  logic          exp_rvalid = 1'b0;
  logic [DW:0]   pend_q [$];

  ram_dp_be #(
    .AWIDTH(AW), .DWIDTH(DW), .BWIDTH(BW),
    .READ_LAT(LAT), .RDW_MODE(RDW), .CLEAR_INIT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .i_rd(i_rd), .i_raddr(i_raddr),
    .i_wr(i_wr), .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wbe(i_wbe),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference behaviour for the coming clock edge, using the currently driven inputs.
  task automatic model_edge();
    logic [DW-1:0] nw;
    logic [DW-1:0] rv;
    logic [DW:0]   item;
    item = '0;
    if (rst) begin
      pend_q.delete();
      exp_rdata  = '1;
      exp_rvalid = 1'b0;
      busy_left  = DEPTH;
      return;
    end
    if (busy_left > 0) begin
      ref_mem[DEPTH - busy_left] = '0;
      busy_left--;
    end else begin
      nw = ref_mem[i_waddr];
      for (int k = 0; k < NB; k++) begin
        if (i_wbe[k]) nw[k*BW +: BW] = i_wdata[k*BW +: BW];
      end
      if (i_rd) begin
        rv   = (i_wr && (i_waddr == i_raddr) && (RDW != 0)) ? nw : ref_mem[i_raddr];
        item = {1'b1, rv};
      end
      if (i_wr) ref_mem[i_waddr] = nw;
    end
    pend_q.push_back(item);
    exp_rvalid = 1'b0;
    if (pend_q.size() > LAT - 1) begin
      item       = pend_q.pop_front();
      exp_rvalid = item[DW];
      if (item[DW]) exp_rdata = item[DW-1:0];
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic [AW-1:0] ra,
                      input logic wr, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [NB-1:0] be);
    @(negedge clk);
    rst     = r;
    i_rd    = rd;
    i_raddr = ra;
    i_wr    = wr;
    i_waddr = wa;
    i_wdata = wd;
    i_wbe   = be;
    model_edge();
    @(posedge clk);
    #1;
    check("busy",   {{(DW-1){1'b0}}, o_busy},   {{(DW-1){1'b0}}, (busy_left > 0)});
    check("rvalid", {{(DW-1){1'b0}}, o_rvalid}, {{(DW-1){1'b0}}, exp_rvalid});
    check("rdata",  o_rdata, exp_rdata);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 16'h0000, 2'b00);
  endtask

  initial begin
    int n;
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;

    rst = 1'b1; i_rd = 1'b0; i_raddr = '0; i_wr = 1'b0;
    i_waddr = '0; i_wdata = '0; i_wbe = '0;

    // Reset, then requests while busy are dropped; clear lasts 16 cycles.
    step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 16'h0000, 2'b00);
    check("reset_rdata", o_rdata, 16'hFFFF);
    n = 0;
    while (o_busy && n < 40) begin
      if (n < 4) step(1'b0, 1'b1, 4'h3, 1'b1, 4'h3, 16'h5555, 2'b11);
      else idle();
      n++;
    end
    check("busy_len", DW'(n), 16'd16);

    // Whole array reads back as zero, pipelined one per cycle.
    for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b1, AW'(a), 1'b0, 4'h0, 16'h0000, 2'b00);
    idle();
    idle();

    // Byte-lane merge.
    step(1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 16'hBEEF, 2'b11);
    step(1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 16'h1234, 2'b10);
    step(1'b0, 1'b1, 4'h5, 1'b0, 4'h0, 16'h0000, 2'b00);
    idle();
    check("t2_rvalid", {15'b0, o_rvalid}, 16'h0001);
    check("t2_rdata",  o_rdata, 16'h12EF);
    idle();
    check("t2_pulse", {15'b0, o_rvalid}, 16'h0000);

    // Same-address read during write returns the merged word.
    step(1'b0, 1'b0, 4'h0, 1'b1, 4'h7, 16'h1111, 2'b11);
    step(1'b0, 1'b1, 4'h7, 1'b1, 4'h7, 16'hAAAA, 2'b01);
    idle();
    check("t3_rdw", o_rdata, 16'h11AA);
    step(1'b0, 1'b1, 4'h7, 1'b0, 4'h0, 16'h0000, 2'b00);
    idle();
    check("t3_later", o_rdata, 16'h11AA);

    // Back-to-back reads with writes to another address.
    step(1'b0, 1'b1, 4'h0, 1'b1, 4'hA, 16'hC001, 2'b11);
    step(1'b0, 1'b1, 4'h1, 1'b1, 4'hA, 16'hC102, 2'b01);
    step(1'b0, 1'b1, 4'h2, 1'b1, 4'hA, 16'hD203, 2'b10);
    idle();
    idle();
    step(1'b0, 1'b1, 4'hA, 1'b0, 4'h0, 16'h0000, 2'b00);
    idle();
    check("t4_write", o_rdata, 16'hD202);

    // Reset mid-clear restarts the full pass; in-flight read is flushed.
    step(1'b0, 1'b1, 4'h5, 1'b0, 4'h0, 16'h0000, 2'b00);
    step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 16'h0000, 2'b00);
    check("t5_flush", {15'b0, o_rvalid}, 16'h0000);
    for (int i = 0; i < 9; i++) idle();
    step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 16'h0000, 2'b00);
    check("t5_rdata", o_rdata, 16'hFFFF);
    n = 0;
    while (o_busy && n < 40) begin
      idle();
      n++;
    end
    check("t5_busy_len", DW'(n), 16'd16);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      ra = AW'($urandom_range(0, DEPTH - 1));
      wa = ($urandom_range(0, 2) == 0) ? ra : AW'($urandom_range(0, DEPTH - 1));
      step(($urandom_range(0, 149) == 0), 1'($urandom), ra, 1'($urandom), wa,
           16'($urandom), 2'($urandom));
    end
    for (int i = 0; i < 20; i++) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
